// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, timing defaults, command bytes.
package ps2_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_WAITCLK,
    S_DATA,
    S_ACK,
    S_WAITIDLE,
    S_DONE,
    S_ERR
  } ps2_state_e;

  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_START_TIMEOUT  = 750000;
  localparam int DEF_XFER_TIMEOUT   = 100000;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_SETLED = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pad plus falling-edge detect.
// sync_o lags the pad by 2 cycles; fall_o is combinational from the synced history.
module ps2_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command sender: inhibit, start, 8 data bits, odd parity, stop, ACK.
// Line updates land 3 cycles after a raw device clock fall; cmdSend is ignored while busy.
module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] cmdData,
  input  logic       cmdSend,
  input  logic       ps2ClkIn,
  input  logic       ps2DatIn,
  output logic       ps2ClkOe,
  output logic       ps2DatOe,
  output logic       busy,
  output logic       cmdDone,
  output logic       cmdError
);

  localparam logic [12:0] INH_LAST   = 13'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] START_LAST = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] XFER_LAST  = 20'(XFER_TIMEOUT - 1);

  ps2_state_e  state_q;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic [3:0]  bit_cnt_q;
  logic [12:0] inh_cnt_q, inh_cnt_d;
  logic [19:0] to_cnt_q, to_cnt_d;
  logic        clk_oe_q, dat_oe_q, busy_q, done_q, err_q;

  logic clk_sync, clk_fall, dat_sync;

  ps2_sync_edge u_clk_sync (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .d_i    (ps2ClkIn),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .d_i    (ps2DatIn),
    .sync_o (dat_sync),
    .fall_o ()
  );

  assign inh_cnt_d = (inh_cnt_q == '1) ? inh_cnt_q : inh_cnt_q + 13'd1;
  assign to_cnt_d  = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 20'd1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmdSend) begin
            shift_q   <= cmdData;
            parity_q  <= odd_parity(cmdData);
            inh_cnt_q <= '0;
            clk_oe_q  <= 1'b1;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt_q == INH_LAST) begin
            dat_oe_q <= 1'b1;
            state_q  <= S_REQ;
          end else begin
            inh_cnt_q <= inh_cnt_d;
          end
        end
        S_REQ: begin
          clk_oe_q <= 1'b0;
          to_cnt_q <= '0;
          state_q  <= S_WAITCLK;
        end
        S_WAITCLK: begin
          if (clk_fall) begin
            dat_oe_q  <= ~shift_q[0];
            bit_cnt_q <= 4'd1;
            to_cnt_q  <= '0;
            state_q   <= S_DATA;
          end else if (to_cnt_q >= START_LAST) begin
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= S_ERR;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        S_DATA, S_ACK, S_WAITIDLE: begin
          // One watchdog covers the whole clocked phase, including the wait for bus idle.
          if (to_cnt_q >= XFER_LAST) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= S_ERR;
          end else begin
            to_cnt_q <= to_cnt_d;
            if (state_q == S_DATA) begin
              if (bit_cnt_q == 4'd10) begin
                state_q <= S_ACK;
              end else if (clk_fall) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd8)
                  dat_oe_q <= ~parity_q;
                else if (bit_cnt_q == 4'd9)
                  dat_oe_q <= 1'b0;
                else
                  dat_oe_q <= ~shift_q[bit_cnt_q[2:0]];
              end
            end else if (state_q == S_ACK) begin
              if (clk_fall) begin
                if (!dat_sync) begin
                  state_q <= S_WAITIDLE;
                end else begin
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_ERR;
                end
              end
            end else if (clk_sync && dat_sync) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ps2ClkOe = clk_oe_q;
  assign ps2DatOe = dat_oe_q;
  assign busy     = busy_q;
  assign cmdDone  = done_q;
  assign cmdError = err_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: behavioural PS/2 device on open-drain lines, frames checked against the byte rules.
module tb_ps2_command_tx;
  import ps2_pkg::*;

  localparam int INH = 50;
  localparam int STO = 2000;
  localparam int XTO = 3000;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_send = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       clk_oe, dat_oe, busy, done, err;
  logic       clk_line, dat_line;

  assign clk_line = dev_clk & ~clk_oe;
  assign dat_line = dev_dat & ~dat_oe;

  ps2_command_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .XFER_TIMEOUT   (XTO)
  ) dut (
    .Clock    (clk),
    .Reset    (rst),
    .cmdData  (cmd_data),
    .cmdSend  (cmd_send),
    .ps2ClkIn (clk_line),
    .ps2DatIn (dat_line),
    .ps2ClkOe (clk_oe),
    .ps2DatOe (dat_oe),
    .busy     (busy),
    .cmdDone  (done),
    .cmdError (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event log sampled on the falling clock edge
  int cyc = 0, done_cnt = 0, err_cnt = 0;
  int t_done = 0, t_err = 0, t_rel = 0, t_clkrise = 0;
  int low_len = 0, last_low_len = 0;
  logic prev_clkoe = 1'b0, prev_busy = 1'b0;
  logic [1:0] busy_around_done = 2'b00, oe_at_err = 2'b00;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clk_oe === 1'b1) begin
      low_len <= low_len + 1;
      if (!prev_clkoe) t_clkrise <= cyc;
    end else if (prev_clkoe) begin
      last_low_len <= low_len;
      low_len <= 0;
      t_rel <= cyc;
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      t_done <= cyc;
      busy_around_done <= {prev_busy, busy};
    end
    if (err === 1'b1) begin
      err_cnt <= err_cnt + 1;
      t_err <= cyc;
      oe_at_err <= {clk_oe, dat_oe};
    end
    prev_clkoe <= (clk_oe === 1'b1);
    prev_busy <= (busy === 1'b1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    cmd_data = b;
    cmd_send = 1'b1;
    wait_cyc(1);
    cmd_send = 1'b0;
  endtask

  // Device: waits for CLK release, then clocks nclk cycles, reading the line on each rising edge.
  // fr[0]=start, fr[8:1]=data, fr[9]=parity, fr[10]=stop.
  task automatic dev_xfer(input int nclk, input bit do_ack, input bit scramble,
                          input int stop_after, output logic [10:0] fr);
    int n = 0;
    fr = '1;
    while (!(busy === 1'b1 && clk_oe === 1'b0) && n < INH + 50) begin
      wait_cyc(1);
      n++;
    end
    check("release", {30'd0, busy, clk_oe}, 32'd2);
    fr[0] = dat_line;
    wait_cyc(5);
    for (int k = 1; k <= nclk; k++) begin
      dev_clk = 1'b0;
      if (scramble) cmd_data = 8'($urandom);
      wait_cyc(H);
      dev_clk = 1'b1;
      if (k <= 10) fr[k] = dat_line;
      if (k == stop_after) return;
      if (k == 10 && do_ack) begin
        wait_cyc(3);
        dev_dat = 1'b0;
        wait_cyc(H - 3);
      end else begin
        wait_cyc(H);
      end
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_end(input int d0, input int e0);
    for (int i = 0; i < XTO && done_cnt == d0 && err_cnt == e0; i++) wait_cyc(1);
  endtask

  task automatic check_frame(input string tag, input logic [10:0] fr, input logic [7:0] b);
    logic exp_par;
    exp_par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    check({tag, "_start"}, {31'd0, fr[0]}, 32'd0);
    check({tag, "_byte"}, {24'd0, fr[8:1]}, {24'd0, b});
    check({tag, "_parity"}, {31'd0, fr[9]}, {31'd0, exp_par});
    check({tag, "_stop"}, {31'd0, fr[10]}, 32'd1);
  endtask

  task automatic do_normal(input logic [7:0] b, input string tag);
    int d0, e0;
    logic [10:0] fr;
    d0 = done_cnt;
    e0 = err_cnt;
    send(b);
    dev_xfer(11, 1'b1, 1'b0, 0, fr);
    wait_end(d0, e0);
    wait_cyc(1);
    check_frame(tag, fr, b);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_noerr"}, err_cnt - e0, 0);
    check({tag, "_clklow"}, last_low_len, INH + 1);
    check({tag, "_busy"}, {30'd0, busy_around_done}, 32'd2);
  endtask

  initial begin
    logic [10:0] fr, fr2;
    logic [7:0]  b, b2;
    int d0, e0;

    #2 rst = 1'b1;
    #1;
    check("rst_clkoe", {31'd0, clk_oe}, 0);
    check("rst_datoe", {31'd0, dat_oe}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_pulses", {30'd0, done, err}, 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);

    do_normal(CMD_SETLED, "setled");
    do_normal(CMD_ENABLE, "enable");

    // Device never clocks
    d0 = done_cnt; e0 = err_cnt;
    send(8'($urandom));
    dev_xfer(0, 1'b0, 1'b0, 0, fr);
    for (int i = 0; i < STO + 100 && err_cnt == e0; i++) wait_cyc(1);
    wait_cyc(1);
    check("sto_err", err_cnt - e0, 1);
    check("sto_nodone", done_cnt - d0, 0);
    check("sto_time", t_err - t_rel, STO);
    check("sto_oe", {30'd0, oe_at_err}, 0);
    check("sto_idle", {31'd0, busy}, 0);

    // Device clocks 11 times but never ACKs
    d0 = done_cnt; e0 = err_cnt;
    b = 8'($urandom);
    send(b);
    dev_xfer(11, 1'b0, 1'b0, 0, fr);
    wait_end(d0, e0);
    wait_cyc(1);
    check_frame("nack", fr, b);
    check("nack_err", err_cnt - e0, 1);
    check("nack_nodone", done_cnt - d0, 0);

    // Reset after the 4th data bit, with bit 3 low so the data line is being pulled
    d0 = done_cnt; e0 = err_cnt;
    b = 8'($urandom) & 8'hF7;
    send(b);
    dev_xfer(11, 1'b1, 1'b0, 4, fr);
    check("mid_bits", {28'd0, fr[4:1]}, {28'd0, b[3:0]});
    check("mid_datoe", {31'd0, dat_oe}, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_oe", {30'd0, clk_oe, dat_oe}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    wait_cyc(2);
    rst = 1'b0;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    wait_cyc(100);
    check("mid_nopulse", (done_cnt - d0) + (err_cnt - e0), 0);
    do_normal(CMD_RESET, "after_rst");

    // cmdSend held high, cmdData churning: only latched bytes go out, back to back
    d0 = done_cnt; e0 = err_cnt;
    b  = 8'($urandom);
    b2 = 8'($urandom);
    cmd_data = b;
    cmd_send = 1'b1;
    wait_cyc(1);
    dev_xfer(11, 1'b1, 1'b1, 0, fr);
    cmd_data = b2;
    wait_end(d0, e0);
    wait_cyc(1);
    cmd_send = 1'b0;
    check_frame("held1", fr, b);
    check("held1_done", done_cnt - d0, 1);
    d0 = done_cnt;
    dev_xfer(11, 1'b1, 1'b0, 0, fr2);
    check("held_restart", t_clkrise - t_done, 2);
    wait_end(d0, e0);
    wait_cyc(1);
    check_frame("held2", fr2, b2);
    check("held2_done", done_cnt - d0, 1);
    check("held_noerr", err_cnt - e0, 0);

    for (int i = 0; i < 3; i++) do_normal(8'($urandom), $sformatf("rnd%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
